alu_controller: RTL
===================

# alu_controller

Multi-cycle sequencer wrapping the combinational `alu`. Accepts one operation per request over a valid/ready handshake and reads operands from an internal 16×16 register file. Drives the ALU, writes the result back and latches flags into a processor status register (PSR). Sits between the instruction decoder and the `alu` instance; one operation is in flight at a time.

## Interface
Parameters:
- DATA_W, 16, datapath width (must match `alu`)
- NREGS, 16, register file depth
- OPC_W, 5, opcode width

Ports:
- clk  in  1  single clock, all state rising-edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_op  in  OPC_W  operation, encodings from `alu_pkg`
- req_rd  in  4  destination/first-source register
- req_rs  in  4  second-source register
- req_use_imm  in  1  B operand is immediate instead of R[rs]
- req_imm  in  8  immediate
- alu_a, alu_b  out  DATA_W  registered operands to `alu`
- alu_op  out  OPC_W  registered opcode to `alu`
- alu_c  in  DATA_W  `alu` result
- alu_flags  in  5  `alu` flags {Z,C,F,L,N} = [4:0]
- done  out  1  one-cycle pulse in WB
- psr  out  5  registered status flags
- dbg_addr  in  4  debug read address
- dbg_data  out  DATA_W  R[dbg_addr], combinational

## Operation
- Opcodes (`alu_pkg`): ADD 00000, ADDU 00001, SUB 00010, CMP 00011, AND 00100, OR 00101, XOR 00110, NOT 00111, LSH 01000, RSH 01001, ARSH 01010, NOP 11111. Unlisted codes are handled as NOP.
- FSM states IDLE→READ→EXEC→WB→IDLE, unconditional after accept.
- IDLE: req_ready=1. On req_valid, latch op/rd/rs/use_imm/imm, go to READ. Otherwise stay.
- READ: alu_a←R[rd]. alu_b←use_imm ? ext(imm) : R[rs]. alu_op←op.
- EXEC: capture alu_c and alu_flags into internal result/flag registers.
- WB: done=1. R[rd]←result unless op is CMP or NOP. psr←captured flags unless op is NOP.
- NOT uses alu_a only; alu_b is still loaded and ignored.
- R0 is an ordinary writable register.
- Reset: all registers including the register file go to 0. State→IDLE, req_ready=1, done=0, psr=0, alu_a=alu_b=0, alu_op=NOP.
- Reset mid-operation aborts with no register-file write and no PSR update.
- dbg_data during the WB cycle returns the pre-write value; the new value is visible from the next cycle.

## Timing
- Accept at edge E0. READ is cycle 1, EXEC is cycle 2, WB is cycle 3 (done high). Register file and PSR update at edge E3. req_ready is high again in cycle 4.
- Latency accept→done: 3 cycles. Throughput: 1 op per 4 cycles.
- req_ready is low in READ/EXEC/WB. req_valid in those states is ignored; the source holds it.
- Back-to-back ops: the second op is accepted in cycle 4 and reads the value written at E3, so there is no hazard.
- alu_a/alu_b/alu_op are stable from E1 until the next accept's READ edge.

## Configuration
- IMM_SIGN_EXT_EN defined: ext(imm) = {{8{imm[7]}}, imm}.
- Not defined: ext(imm) = {8'h00, imm}.
- Example: imm 8'hFF gives 16'hFFFF with the macro and 16'h00FF without it.

## Structure
- `alu_pkg` holds the opcode constants, flag bit indices (FLG_Z=4, FLG_C=3, FLG_F=2, FLG_L=1, FLG_N=0) and the FSM state encoding. `alu` is also to import it.
- One natural sub-module, `alu_regfile`:
  - 16×16 storage with async reset.
  - Two combinational read ports (operands) plus one for debug.
  - One synchronous write port.
- The FSM, operand registers and PSR stay in `alu_controller`.

## Test plan
- Reset, then R1=0, R2=0. ADD rd=1, rs=2 → done pulse in cycle 3, R1=0, psr[4] (Z)=1, req_ready low for 3 cycles.
- Preload via ADD-immediate R1=5, R2=3 (separate ops). SUB rd=1, rs=2 → R1=2, Z=0. The next op is accepted exactly 4 cycles after the previous one.
- R1=2, R2=7. CMP rd=1, rs=2 → R1 unchanged (2), psr[1:0]=2'b11, dbg_data(1)=2.
- ADD rd=3, use_imm=1, imm=8'hFF, R3=1 → R3=16'h0000 with IMM_SIGN_EXT_EN, 16'h0100 without.
- Assert rst during EXEC of ADD rd=4 → R4=0, psr=0, done never pulses, req_ready=1 immediately.
- NOP and opcode 5'b10110 → no register-file write, psr unchanged, done still pulses in cycle 3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its controller: opcodes, flag bit indices,
// sequencer state encoding and small opcode-decode helpers.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 16;
    localparam int unsigned ALU_NREGS  = 16;
    localparam int unsigned ALU_OPC_W  = 5;

    localparam logic [ALU_OPC_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [ALU_OPC_W-1:0] OP_ADDU = 5'b00001;
    localparam logic [ALU_OPC_W-1:0] OP_SUB  = 5'b00010;
    localparam logic [ALU_OPC_W-1:0] OP_CMP  = 5'b00011;
    localparam logic [ALU_OPC_W-1:0] OP_AND  = 5'b00100;
    localparam logic [ALU_OPC_W-1:0] OP_OR   = 5'b00101;
    localparam logic [ALU_OPC_W-1:0] OP_XOR  = 5'b00110;
    localparam logic [ALU_OPC_W-1:0] OP_NOT  = 5'b00111;
    localparam logic [ALU_OPC_W-1:0] OP_LSH  = 5'b01000;
    localparam logic [ALU_OPC_W-1:0] OP_RSH  = 5'b01001;
    localparam logic [ALU_OPC_W-1:0] OP_ARSH = 5'b01010;
    localparam logic [ALU_OPC_W-1:0] OP_NOP  = 5'b11111;

    localparam int unsigned FLG_Z = 4;
    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_F = 2;
    localparam int unsigned FLG_L = 1;
    localparam int unsigned FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic op_known(input logic [ALU_OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_ADDU, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_LSH, OP_RSH, OP_ARSH, OP_NOP: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // CMP only produces flags; NOP touches nothing
    function automatic logic op_writes_rf(input logic [ALU_OPC_W-1:0] op);
        return !(op == OP_CMP || op == OP_NOP);
    endfunction

endpackage

// File: rtl/alu_controller_if.sv
// Request handshake between the instruction decoder (master) and alu_controller (slave).
interface alu_controller_if #(
    parameter int unsigned OPC_W = alu_pkg::ALU_OPC_W
) ();

    logic             req_valid;
    logic             req_ready;
    logic [OPC_W-1:0] req_op;
    logic [3:0]       req_rd;
    logic [3:0]       req_rs;
    logic             req_use_imm;
    logic [7:0]       req_imm;

    modport master (
        output req_valid, req_op, req_rd, req_rs, req_use_imm, req_imm,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs, req_use_imm, req_imm,
        output req_ready
    );

endinterface

// File: rtl/alu_regfile.sv
// Register file: async-reset storage, two operand read ports, one debug read
// port (all combinational) and one synchronous write port.
module alu_regfile #(
    parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W,
    parameter int unsigned NREGS  = alu_pkg::ALU_NREGS,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_controller.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) feeding the external combinational alu.
// Define IMM_SIGN_EXT_EN to sign-extend the 8-bit immediate; otherwise it is zero-extended.
module alu_controller
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned NREGS  = ALU_NREGS,
    parameter int unsigned OPC_W  = ALU_OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_controller_if.slave   req,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [4:0]        alu_flags,
    output logic              done,
    output logic [4:0]        psr,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    function automatic logic [DATA_W-1:0] ext_imm(input logic [7:0] imm);
`ifdef IMM_SIGN_EXT_EN
        return {{(DATA_W-8){imm[7]}}, imm};
`else
        return {{(DATA_W-8){1'b0}}, imm};
`endif
    endfunction

    state_e            state;
    logic [OPC_W-1:0]  op_q;
    logic [3:0]        rd_q;
    logic [3:0]        rs_q;
    logic              use_imm_q;
    logic [7:0]        imm_q;
    logic [DATA_W-1:0] res_q;
    logic [4:0]        flg_q;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic              wb_we;

    assign wb_we = (state == ST_WB) && op_writes_rf(op_q);

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (4)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_we),
        .wa       (rd_q),
        .wd       (res_q),
        .ra_addr  (rd_q),
        .ra_data  (rf_a),
        .rb_addr  (rs_q),
        .rb_data  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Sequencer with registered handshake, operand and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            req.req_ready <= 1'b1;
            op_q          <= OP_NOP;
            rd_q          <= '0;
            rs_q          <= '0;
            use_imm_q     <= 1'b0;
            imm_q         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= OP_NOP;
            res_q         <= '0;
            flg_q         <= '0;
            done          <= 1'b0;
            psr           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req.req_valid) begin
                        // unlisted opcodes collapse to NOP at accept time
                        op_q          <= op_known(req.req_op) ? req.req_op : OP_NOP;
                        rd_q          <= req.req_rd;
                        rs_q          <= req.req_rs;
                        use_imm_q     <= req.req_use_imm;
                        imm_q         <= req.req_imm;
                        req.req_ready <= 1'b0;
                        state         <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_a  <= rf_a;
                    alu_b  <= use_imm_q ? ext_imm(imm_q) : rf_b;
                    alu_op <= op_q;
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= alu_c;
                    flg_q <= alu_flags;
                    done  <= 1'b1;
                    state <= ST_WB;
                end
                ST_WB: begin
                    if (op_q != OP_NOP) begin
                        psr <= flg_q;
                    end
                    done          <= 1'b0;
                    req.req_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
